// File: rtl/edge_bin_packer_if.sv
// Byte stream from the edge bin packer to the frame writer.
//   data  : packed binarised pixels, bit k = k-th pixel of the group
//   valid : data holds an unread byte
//   ready : consumer takes the byte when valid && ready
//   eol   : byte is the last of a row
//   eof   : byte is the last of a frame
interface edge_bin_packer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       eol;
  logic       eof;

  modport master (output data, output valid, output eol, output eof, input ready);
  modport slave  (input data, input valid, input eol, input eof, output ready);
endinterface

// File: rtl/edge_bin_packer.sv
// Binarises the edge-magnitude stream against a per-frame threshold, packs the bits 8 per byte
// LSB first (rows zero-padded to a whole byte) and buffers the bytes in a small FIFO.
// The pixel source cannot be stalled, so bytes arriving at a full FIFO are dropped and flagged.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pix_i          : edge magnitude, unsigned
//   pix_valid_i    : pix_i is a valid windowed pixel this cycle
//   thresh_i       : threshold, sampled at the first pixel of each frame
//   byte_io        : packed byte stream (valid/ready, eol/eof tags)
//   overflow_o     : sticky, a byte was dropped
//   ovf_clr_i      : synchronous clear of overflow_o (a same-cycle drop wins)
//   frame_done_o   : one-cycle pulse after the last byte of a frame is pushed
module edge_bin_packer #(
  parameter int unsigned W         = 478,
  parameter int unsigned H         = 855,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               pix_i,
  input  logic                     pix_valid_i,
  input  logic [7:0]               thresh_i,
  edge_bin_packer_if.master        byte_io,
  output logic                     overflow_o,
  input  logic                     ovf_clr_i,
  output logic                     frame_done_o
);

  localparam int unsigned ColW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RowW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        thr_q, thr_d;
  logic              overflow_q, overflow_d;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]        mem_q [FifoDepth];

  logic [7:0]        thr_use;
  logic              pix_bit, last_col, last_row;
  logic [7:0]        packed_byte;
  logic              push_req, push, pop, drop, full, empty;
  logic [PtrW:0]     count;

  // Outside a frame the incoming thresh applies to the pixel that starts the frame.
  assign thr_use     = (state_q == StActive) ? thr_q : thresh_i;
  assign pix_bit     = (pix_i >= thr_use);
  assign last_col    = (col_q == ColW'(W - 1));
  assign last_row    = (row_q == RowW'(H - 1));
  assign packed_byte = shift_q | (8'(pix_bit) << bit_cnt_q);
  assign push_req    = pix_valid_i && ((bit_cnt_q == 3'd7) || last_col);

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (PtrW + 1)'(FifoDepth));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign pop   = !empty && byte_io.ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    thr_d      = thr_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q + (PtrW + 1)'(push);
    rd_ptr_d   = rd_ptr_q + (PtrW + 1)'(pop);

    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end

    if (pix_valid_i) begin
      // Counters advance even when the byte is dropped, keeping row alignment.
      thr_d     = thr_use;
      shift_d   = push_req ? 8'h00 : packed_byte;
      bit_cnt_d = push_req ? 3'd0 : bit_cnt_q + 3'd1;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      state_d = (last_col && last_row) ? StDone : StActive;
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      thr_q      <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      thr_q      <= thr_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is reset so the byte outputs read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= {last_col && last_row, last_col, packed_byte};
    end
  end

  assign byte_io.valid = !empty;
  assign {byte_io.eof, byte_io.eol, byte_io.data} = mem_q[rd_ptr_q[PtrW-1:0]];
  assign overflow_o    = overflow_q;
  assign frame_done_o  = (state_q == StDone);

endmodule

// File: doc/edge_bin_packer.md
Name: edge_bin_packer

Overview:
- Consumes the 8-bit edge-magnitude stream (pixel + valid) produced by the 3x3 convolution stage.
- Binarises each valid pixel against a threshold and packs the resulting bits 8 per byte, LSB first, with zero padding at the end of each row.
- Buffers the bytes in a small FIFO and presents them on a valid/ready interface to the frame writer.
- The upstream stage cannot be stalled, so any byte that cannot be buffered is dropped and flagged.

Parameters:
- W, 478: valid pixels per output row (input row width minus 2).
- H, 855: valid rows per frame.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of two, >= 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  8  edge magnitude, unsigned.
- pix_valid  in  1  pix_in is a valid windowed pixel this cycle; no backpressure upstream.
- thresh  in  8  binarisation threshold.
- byte_data  out  8  packed bits; bit k is the k-th pixel of the group.
- byte_valid  out  1  byte_data holds an unread byte.
- byte_ready  in  1  consumer accepts the byte when byte_valid && byte_ready.
- byte_eol  out  1  current byte is the last byte of a row.
- byte_eof  out  1  current byte is the last byte of a frame.
- overflow  out  1  sticky; set when a byte was dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is pushed.

Behaviour:
- Reset (reset low, asynchronous):
  - all outputs 0; FIFO empty; col, row, bit_cnt and shift register 0; FSM in IDLE; thr_q = 0.
  - On release, the first edge with pix_valid is frame pixel (0,0).
- FSM states:
  - IDLE: no frame in progress. On pix_valid: latch thr_q <= thresh, process the pixel with the newly latched thresh, go to ACTIVE.
  - ACTIVE: process every pix_valid cycle. After the pixel at (col=W-1, row=H-1): go to DONE.
  - DONE: assert frame_done for exactly that one cycle, then return to IDLE. A pix_valid arriving in DONE is treated as (0,0) of the next frame, and the IDLE latch rules apply to it.
- Threshold: thresh is sampled only at frame start; changes mid-frame have no effect.
- Per-pixel processing:
  - bit = (pix_in >= thr_q), unsigned compare.
  - The bit is written at position bit_cnt; bit_cnt increments and col increments.
- Byte push happens on the same edge that samples the completing pixel, when bit_cnt reaches 7 or col == W-1.
  - Pushed byte = shift contents plus the new bit; unused upper bits are 0.
  - bit_cnt resets to 0; the shift register clears.
  - eol/eof tags are stored alongside the byte.
- Row/column wrap:
  - col wraps W-1 -> 0 and row increments.
  - row wraps H-1 -> 0 at frame end.
  - A partial byte never spans rows.
- Bytes per row = ceil(W/8); for default W: 60 bytes, the last holding 6 valid bits.
- Output timing:
  - byte_valid rises in the cycle after the push edge, i.e. 1-cycle latency from the completing pixel.
  - byte_data, byte_eol and byte_eof are held stable while byte_valid && !byte_ready.
- FIFO:
  - Pop on byte_valid && byte_ready.
  - Push and pop on the same edge are both performed, including when full, so no overflow occurs in that case.
  - If the FIFO is full, no pop occurs and a push is requested: the byte is dropped and overflow <= 1. Counters still advance so row alignment is preserved.
- overflow:
  - Cleared by ovf_clr.
  - If a set event and ovf_clr occur on the same edge, set wins.
- Reset mid-frame: the partial byte and buffered bytes are discarded; no frame_done is generated.
- Gaps: pix_valid may deassert for any number of cycles; state is held.

Test Plan (W=10, H=2, FIFO_DEPTH=4 unless noted):
1. thresh=100; one row of pix_in = 0,100,99,255,0,0,0,200,150,50 with byte_ready=1 → bytes 0x8A (eol=0) then 0x01 (eol=1). Each byte_valid rises 1 cycle after its completing pixel.
2. Full frame of all 255, byte_ready=1 → 4 bytes 0xFF, 0x03, 0xFF, 0x03. Last byte has eol=1 and eof=1. frame_done pulses once, on the edge of the 20th pixel.
3. byte_ready=0 for the whole frame of scenario 2 → first 4 bytes buffered, overflow=0. Second frame: first byte dropped and overflow=1. Assert ovf_clr → overflow=0. byte_data is held throughout the stall.
4. Change thresh from 100 to 10 mid-frame with pix_in=50 → bits stay 0 until the next frame. In the next frame the bits are 1 (first byte 0xFF).
5. Pull reset low after 13 pixels → byte_valid=0, overflow=0. The next pixel is treated as (0,0) and the first byte is packed fresh.
6. FIFO full with byte_ready=1 on the same edge as a push → no overflow, byte order preserved.
